// File: rtl/arb_pkg.sv
// arb_pkg: shared types and sizes for the 4-requester round-robin arbiter.
package arb_pkg;
   typedef enum logic {IDLE, GRANT} arb_state_t;
   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;
   localparam int CNT_W   = 8;
endpackage

// File: rtl/mux_4x1.sv
// mux_4x1: combinational 4:1 bit select.
module mux_4x1 (
   input  logic [1:0] sel,
   input  logic [3:0] in,
   output logic       out
);
   assign out = in[sel];
endmodule

// File: rtl/rr_pick_4.sv
// rr_pick_4: combinational round-robin picker, first set req after rr_ptr wins.
module rr_pick_4
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   rr_ptr,
   output logic [SEL_W-1:0]   pick,
   output logic               any
);
   logic [SEL_W-1:0] idx;
   // Walk from the farthest offset down so the nearest set bit is assigned last.
   always_comb begin
      pick = '0;
      idx  = '0;
      any  = |req;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = rr_ptr + SEL_W'(k);
         if (req[idx]) pick = idx;
      end
   end
endmodule

// File: rtl/rr_arb_4x1.sv
// rr_arb_4x1: round-robin arbiter sharing a 4:1 bit mux over valid/ready.
// Define ARB_GRANT_CNT_EN to add saturating per-requester grant counters.
module rr_arb_4x1
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ-1:0]       data,
   input  logic                     out_ready,
   output logic [NUM_REQ-1:0]       grant,
   output logic [SEL_W-1:0]         sel,
   output logic                     out_valid,
   output logic                     out_data
`ifdef ARB_GRANT_CNT_EN
   ,
   output logic [NUM_REQ*CNT_W-1:0] grant_cnt
`endif
);
   localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
   arb_state_t       state;
   logic [HW-1:0]    hold_cnt;
   logic [SEL_W-1:0] rr_ptr, pick;
   logic             any, xfer, last;
   rr_pick_4 u_pick (.req(req), .rr_ptr(rr_ptr), .pick(pick), .any(any));
   mux_4x1 u_mux (.sel(sel), .in(data), .out(out_data));
   assign out_valid = (state == GRANT) & req[sel];
   assign xfer      = out_valid & out_ready;
   assign last      = hold_cnt == HW'(MAX_HOLD - 1);
   // Withdrawal and forced release both fall back to IDLE for one arbitration cycle.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= IDLE;
         grant    <= '0;
         sel      <= '0;
         hold_cnt <= '0;
         rr_ptr   <= SEL_W'(NUM_REQ - 1);
      end else if (state == IDLE) begin
         if (any) begin
            state    <= GRANT;
            grant    <= NUM_REQ'(1) << pick;
            sel      <= pick;
            rr_ptr   <= pick;
            hold_cnt <= '0;
         end
      end else if (!req[sel] || (xfer && last)) begin
         state <= IDLE;
         grant <= '0;
      end else if (xfer) hold_cnt <= hold_cnt + 1'b1;
`ifdef ARB_GRANT_CNT_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) grant_cnt <= '0;
      else if (state == IDLE && any && grant_cnt[pick*CNT_W +: CNT_W] != '1)
         grant_cnt[pick*CNT_W +: CNT_W] <= grant_cnt[pick*CNT_W +: CNT_W] + 1'b1;
`endif
endmodule

// File: tb/tb_rr_arb_4x1.sv
// tb_rr_arb_4x1: directed scoreboard bench; transfers are checked by a negedge monitor.
module tb_rr_arb_4x1;
   logic clk = 0, rst_n = 0;
   logic [3:0] req = 0, data = 0, grant;
   logic [1:0] sel;
   logic out_ready = 0, out_valid, out_data;
   logic [3:0] req1 = 0, grant1;
   logic [1:0] sel1;
   logic out_ready1 = 1, out_valid1, out_data1;
   int checks = 0, errors = 0;
   logic [6:0] exp_q[$];
`ifdef ARB_GRANT_CNT_EN
   logic [31:0] grant_cnt, grant_cnt1;
`endif

   always #5 clk = ~clk;

   rr_arb_4x1 #(.MAX_HOLD(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .data(data), .out_ready(out_ready),
      .grant(grant), .sel(sel), .out_valid(out_valid), .out_data(out_data)
`ifdef ARB_GRANT_CNT_EN
      , .grant_cnt(grant_cnt)
`endif
   );

   rr_arb_4x1 #(.MAX_HOLD(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req(req1), .data(4'b0001), .out_ready(out_ready1),
      .grant(grant1), .sel(sel1), .out_valid(out_valid1), .out_data(out_data1)
`ifdef ARB_GRANT_CNT_EN
      , .grant_cnt(grant_cnt1)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int g, input int n, input logic b);
      logic [3:0] oh;
      oh = 4'b0001 << g;
      repeat (n) exp_q.push_back({oh, 2'(g), b});
   endtask

   // Monitor: every transfer must match the next expected {grant, sel, out_data}.
   always @(negedge clk)
      if (rst_n && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL xfer: unexpected transfer grant=%b sel=%0d at %0t", grant, sel, $time);
         end else begin
            automatic logic [6:0] e = exp_q.pop_front();
            if ({grant, sel, out_data} !== e) begin
               errors++;
               $display("FAIL xfer: got %b expected %b at %0t", {grant, sel, out_data}, e, $time);
            end
         end
      end

   initial begin
      tick(2);
      chk("reset_grant", grant, 0);
      chk("reset_sel", sel, 0);
      chk("reset_valid", out_valid, 0);
      rst_n = 1;
      req = 4'b0100;
      tick(1);
      chk("pre_reset_grant", grant, 4'b0100);
      chk("pre_reset_valid", out_valid, 1);
      #3 rst_n = 0;
      #1;
      chk("async_reset_grant", grant, 0);
      chk("async_reset_valid", out_valid, 0);
      @(posedge clk);
      #1;
      rst_n = 1;
      // Rotation from reset: req0 first, four transfers per grant, one IDLE gap.
      req = 4'b1111; data = 4'b1010; out_ready = 1;
      push(0, 4, 0); push(1, 4, 1); push(2, 4, 0); push(3, 4, 1); push(0, 4, 0);
      for (int g = 0; g < 5; g++) begin
         tick(1);
         chk("rot_grant", grant, 32'(4'b0001 << (g % 4)));
         tick(4);
         chk("rot_idle", grant, 0);
      end
      req = 0;
      tick(1);
      // Single requester: grant next cycle, release, then re-grant.
      req = 4'b0010; data = 4'b0010;
      push(1, 8, 1);
      tick(1);
      chk("single_grant", grant, 4'b0010);
      chk("single_sel", sel, 1);
      chk("single_valid", out_valid, 1);
      chk("single_data", out_data, 1);
      tick(4);
      chk("single_idle", grant, 0);
      tick(1);
      chk("single_regrant", grant, 4'b0010);
      tick(4);
      req = 0;
      tick(1);
      // Backpressure: one transfer, stall ten cycles, then exactly three more.
      req = 4'b0100; data = 4'b0100;
      push(2, 4, 1);
      tick(1);
      chk("bp_grant", grant, 4'b0100);
      tick(1);
      out_ready = 0;
      tick(10);
      chk("bp_hold_grant", grant, 4'b0100);
      chk("bp_hold_valid", out_valid, 1);
      out_ready = 1;
      tick(2);
      chk("bp_not_yet_released", grant, 4'b0100);
      tick(1);
      chk("bp_released", grant, 0);
      req = 0;
      tick(1);
      // Withdrawal: req2 drops after two transfers, req3 then wins.
      req = 4'b0100; data = 4'b0100;
      tick(1);
      chk("wd_grant", grant, 4'b0100);
      req = 4'b1100;
      push(2, 2, 1); push(3, 4, 0);
      tick(2);
      req = 4'b1000;
      #1;
      chk("wd_valid_drop", out_valid, 0);
      tick(1);
      chk("wd_idle", grant, 0);
      tick(1);
      chk("wd_next", grant, 4'b1000);
      tick(4);
      chk("wd_release", grant, 0);
      req = 0;
      tick(2);
      chk("queue_drained", exp_q.size(), 0);
`ifdef ARB_GRANT_CNT_EN
      chk("grant_cnt", grant_cnt, {8'd2, 8'd3, 8'd3, 8'd2});
`endif
      // MAX_HOLD=1: one transfer per grant, alternating with IDLE.
      req1 = 4'b0001;
      tick(1);
      chk("mh1_grant", grant1, 4'b0001);
      chk("mh1_valid", out_valid1, 1);
      tick(1);
      chk("mh1_idle", grant1, 0);
      tick(1);
      chk("mh1_regrant", grant1, 4'b0001);
`ifdef ARB_GRANT_CNT_EN
      tick(600);
      chk("grant_cnt_sat", grant_cnt1, 32'h0000_00ff);
`endif
      req1 = 0;
      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
